// File: rtl/dual_port_ram.sv
// Simple-dual-port synchronous RAM with per-lane write mask, write-first bypass,
// optional output register and a hardware clear engine that zeroes the array.
module dual_port_ram #(
    parameter int BYTE_W   = 8,
    parameter int LANES    = 1,
    parameter int ADDR_W   = 8,
    parameter int NUM_ADDR = 1 << ADDR_W,
    parameter int OUT_REG  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_req,
    output logic                      ready,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [BYTE_W*LANES-1:0]   wr_data,
    input  logic [LANES-1:0]          wr_mask,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [BYTE_W*LANES-1:0]   rd_data,
    output logic                      rd_valid
);

    localparam int DATA_W = BYTE_W * LANES;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  clr_addr, clr_addr_nxt;
    logic               clr_last;
    logic               accept;
    logic               wr_go;
    logic               rd_go;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  s1_data;
    logic               s1_valid;

    // NOTE: the array has no reset; the clear engine zeroes it instead, which keeps it mappable to block RAM.
    logic [DATA_W-1:0]  mem [NUM_ADDR];

    assign clr_last = (int'(clr_addr) == NUM_ADDR - 1);
    assign ready    = (state == S_IDLE);
    // The cycle that samples clr_req belongs to the clear, so port traffic is dropped there too.
    assign accept   = ready & ~clr_req & ~rst;
    assign wr_go    = wr_en & accept & (int'(wr_addr) < NUM_ADDR);
    assign rd_go    = rd_en & accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // NOTE: every output of an always_comb is assigned a default first so no latch can be inferred.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            S_CLEAR: begin
                clr_addr_nxt = clr_addr + ADDR_W'(1);
                if (clr_last) begin
                    state_nxt    = S_IDLE;
                    clr_addr_nxt = '0;
                end
            end
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt    = S_CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (wr_go) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_mask[k]) begin
                    mem[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Write-first: lanes being written on the same edge are forwarded from wr_data.
    always_comb begin
        rd_word = '0;
        if (int'(rd_addr) < NUM_ADDR) begin
            rd_word = mem[rd_addr];
            for (int k = 0; k < LANES; k++) begin
                if (wr_go && (wr_addr == rd_addr) && wr_mask[k]) begin
                    rd_word[k*BYTE_W +: BYTE_W] = wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_go;
            if (rd_go) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] o_data;
            logic              o_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    o_valid <= 1'b0;
                    o_data  <= '0;
                end else begin
                    o_valid <= s1_valid;
                    if (s1_valid) begin
                        o_data <= s1_data;
                    end
                end
            end

            assign rd_data  = o_data;
            assign rd_valid = o_valid;
        end else begin : g_no_out_reg
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule
